// File: rtl/ps2_pkg.sv
// Shared constants and helpers for the PS/2 device-to-host receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ERR_TIMEOUT = 2'b00,
    ERR_START   = 2'b01,
    ERR_PARITY  = 2'b10,
    ERR_STOP    = 2'b11
  } err_code_e;

  localparam int PS2_FRAME_BITS = 11;

  function automatic int unsigned us_to_cycles(input int unsigned freq_hz,
                                               input int unsigned time_us);
    return (freq_hz / 1000000) * time_us;
  endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Register-file side of the PS/2 receiver: byte/error reporting and the bit count.
interface ps2_rx_if;
  logic       tx_mode;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_avail;
  logic       rx_err;
  logic [1:0] rx_err_code;
  logic       rx_overrun;
  logic [4:0] rx_bitcount;

  // Register file / CTRLps2 side
  modport master (
    output tx_mode, rx_ack,
    input  rx_data, rx_valid, rx_avail, rx_err, rx_err_code, rx_overrun, rx_bitcount
  );

  // Receiver side
  modport slave (
    input  tx_mode, rx_ack,
    output rx_data, rx_valid, rx_avail, rx_err, rx_err_code, rx_overrun, rx_bitcount
  );
endinterface

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer followed by a glitch filter; emits the filtered level and a fall strobe.
module ps2_sync_filter #(
  parameter int filter_len = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(filter_len + 1);

  logic          meta_q, sync_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CW'(filter_len - 1)) level_d = sync_q;
      else                              cnt_d   = cnt_q + 1'b1;
    end
    fall_d = level_q & ~level_d;
  end

  // Idle PS/2 bus is high, so the whole chain comes out of reset at 1.
  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      meta_q  <= din;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: counts ps2_clk falls, deframes 11-bit frames, reports bytes/errors.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned clk_freq   = 50000000,
  parameter int unsigned timeout_us = 1000,
  parameter int          filter_len = 4
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  ps2_rx_if.slave bus
);

  localparam int unsigned TMO_CYCLES = us_to_cycles(clk_freq, timeout_us);
  localparam int          TMO_W      = $clog2(TMO_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TMO_CYCLES);
  localparam logic [4:0]       LAST_EDGE = 5'(PS2_FRAME_BITS - 1);

  logic clk_level, clk_fall;
  logic data_meta_q, data_s_q;

  ps2_sync_filter #(.filter_len(filter_len)) u_clk_filter (
    .clk   (sys_clk),
    .rst_n (sys_rst),
    .din   (ps2_clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  logic [4:0]                bitcount_q, bitcount_d;
  logic [PS2_FRAME_BITS-1:0] shift_q, shift_d;
  logic                      check_q, check_d;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic [7:0]                data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      avail_q, avail_d;
  logic                      err_q, err_d;
  err_code_e                 code_q, code_d;
  logic                      overrun_q, overrun_d;
  logic                      expire;

  // Timeout takes precedence over a coincident fall.
  assign expire = (bitcount_q != 5'd0) && (tmo_q == '0);

  always_comb begin
    bitcount_d = bitcount_q;
    shift_d    = shift_q;
    check_d    = 1'b0;
    tmo_d      = tmo_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;

    if (expire) begin
      bitcount_d = 5'd0;
      shift_d    = '0;
      tmo_d      = TMO_LOAD;
      err_d      = 1'b1;
      code_d     = ERR_TIMEOUT;
    end else if (clk_fall) begin
      tmo_d = TMO_LOAD;
      if (bitcount_q == LAST_EDGE) begin
        bitcount_d = 5'd0;
        check_d    = ~bus.tx_mode;
      end else begin
        bitcount_d = bitcount_q + 5'd1;
      end
      // Bits enter at the top so the start bit lands in bit 0 after eleven shifts.
      if (!bus.tx_mode) shift_d = {data_s_q, shift_q[PS2_FRAME_BITS-1:1]};
    end else if (bitcount_q == 5'd0) begin
      tmo_d = TMO_LOAD;
    end else begin
      tmo_d = tmo_q - 1'b1;
    end

    // shift_q = {stop, parity, d7..d0, start}
    if (check_q) begin
      if (shift_q[0]) begin
        err_d  = 1'b1;
        code_d = ERR_START;
      end else if (!(^shift_q[9:1])) begin
        err_d  = 1'b1;
        code_d = ERR_PARITY;
      end else if (!shift_q[10]) begin
        err_d  = 1'b1;
        code_d = ERR_STOP;
      end else begin
        valid_d = 1'b1;
        data_d  = shift_q[8:1];
      end
    end

    // A new byte beats a coincident acknowledge.
    if (valid_q)         avail_d = 1'b1;
    else if (bus.rx_ack) avail_d = 1'b0;
    else                 avail_d = avail_q;

    if (bus.rx_ack)              overrun_d = 1'b0;
    else if (valid_q && avail_q) overrun_d = 1'b1;
    else                         overrun_d = overrun_q;
  end

  // NOTE: the shift register sits under reset too; a reset mid-frame must not leak stale bits.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      data_meta_q <= 1'b1;
      data_s_q    <= 1'b1;
      bitcount_q  <= 5'd0;
      shift_q     <= '0;
      check_q     <= 1'b0;
      tmo_q       <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      avail_q     <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_TIMEOUT;
      overrun_q   <= 1'b0;
    end else begin
      data_meta_q <= ps2_data_in;
      data_s_q    <= data_meta_q;
      bitcount_q  <= bitcount_d;
      shift_q     <= shift_d;
      check_q     <= check_d;
      tmo_q       <= tmo_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      avail_q     <= avail_d;
      err_q       <= err_d;
      code_q      <= code_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.rx_avail    = avail_q;
  assign bus.rx_err      = err_q;
  assign bus.rx_err_code = code_q;
  assign bus.rx_overrun  = overrun_q;
  assign bus.rx_bitcount = bitcount_q;

  logic unused_level;
  assign unused_level = clk_level;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: frames are driven bit by bit, expected outcomes queued and
// compared when the receiver reports a byte or an error.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int HALF = 20;  // sys_clk cycles per PS/2 clock half-period

  typedef struct packed {
    logic       is_err;
    logic [1:0] code;
    logic [7:0] data;
  } exp_t;

  logic sys_clk = 1'b0;
  logic rst_n;
  logic ps2_clk_in, ps2_data_in;

  ps2_rx_if bus ();

  ps2_rx dut (
    .sys_clk     (sys_clk),
    .sys_rst     (rst_n),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .bus         (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic [7:0] last_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Drives the first n bits of a frame (bit 0 first), checking rx_bitcount after each fall.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data_in = bits[i];
      wait_cycles(HALF);
      ps2_clk_in = 1'b0;
      wait_cycles(HALF);
      check("bitcount", 32'(bus.rx_bitcount), (i == 10) ? 32'd0 : 32'(i + 1));
      ps2_clk_in = 1'b1;
    end
    wait_cycles(HALF);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic start);
    exp_t e;
    if (!bus.tx_mode) begin
      e.is_err = 1'b1;
      e.data   = last_data;
      if (start)            e.code = 2'b01;
      else if (!(^{d, par})) e.code = 2'b10;
      else if (!stop)       e.code = 2'b11;
      else begin
        e.is_err  = 1'b0;
        e.code    = 2'b00;
        e.data    = d;
        last_data = d;
      end
      sb.push_back(e);
    end
    send_bits({stop, par, d, start}, 11);
    wait_cycles(5);
  endtask

  task automatic ack_pulse();
    bus.rx_ack = 1'b1;
    wait_cycles(1);
    bus.rx_ack = 1'b0;
    wait_cycles(2);
  endtask

  // Scoreboard: every valid/error pulse must match the oldest queued expectation.
  always @(negedge sys_clk) begin : monitor
    exp_t e;
    if (rst_n && (bus.rx_valid || bus.rx_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({bus.rx_valid, bus.rx_err}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 32'({bus.rx_valid, bus.rx_err}), e.is_err ? 32'd1 : 32'd2);
        check("rx_data", 32'(bus.rx_data), 32'(e.data));
        if (e.is_err) check("err_code", 32'(bus.rx_err_code), 32'(e.code));
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    ps2_clk_in  = 1'b1;
    ps2_data_in = 1'b1;
    bus.tx_mode = 1'b0;
    bus.rx_ack  = 1'b0;
    wait_cycles(5);
    check("reset_bitcount", 32'(bus.rx_bitcount), 32'd0);
    check("reset_avail", 32'({bus.rx_avail, bus.rx_overrun, bus.rx_valid, bus.rx_err}), 32'd0);
    check("reset_data", 32'(bus.rx_data), 32'd0);
    rst_n = 1'b1;
    wait_cycles(5);

    // Good byte
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("avail_after_good", 32'(bus.rx_avail), 32'd1);
    check("data_after_good", 32'(bus.rx_data), 32'h1C);
    ack_pulse();
    check("avail_after_ack", 32'(bus.rx_avail), 32'd0);

    // Back-to-back without acknowledge
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    check("overrun_first", 32'(bus.rx_overrun), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("b2b_data", 32'(bus.rx_data), 32'h1C);
    check("b2b_overrun", 32'(bus.rx_overrun), 32'd1);
    ack_pulse();
    check("ack_clears", 32'({bus.rx_avail, bus.rx_overrun}), 32'd0);

    // Parity, stop and start errors
    send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
    check("parity_hold_data", 32'(bus.rx_data), 32'h1C);
    check("parity_no_avail", 32'(bus.rx_avail), 32'd0);
    send_frame(8'hAA, 1'b1, 1'b0, 1'b0);
    check("stop_code", 32'(bus.rx_err_code), 32'(ERR_STOP));

    // Timeout after five falls, then recovery
    sb.push_back('{is_err: 1'b1, code: 2'b00, data: last_data});
    send_bits({1'b1, 1'b1, 8'h00, 1'b0}, 5);
    check("partial_bitcount", 32'(bus.rx_bitcount), 32'd5);
    wait_cycles(52000);
    check("timeout_bitcount", 32'(bus.rx_bitcount), 32'd0);
    check("timeout_seen", 32'(sb.size()), 32'd0);
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    check("recover_data", 32'(bus.rx_data), 32'h55);
    send_frame(8'h12, 1'b1, 1'b1, 1'b1);
    check("start_code", 32'(bus.rx_err_code), 32'(ERR_START));

    // Glitch on ps2_clk shorter than the filter
    ps2_clk_in = 1'b0;
    wait_cycles(2);
    ps2_clk_in = 1'b1;
    wait_cycles(20);
    check("glitch_bitcount", 32'(bus.rx_bitcount), 32'd0);

    // Reset mid-frame
    send_bits({1'b1, 1'b0, 8'h3A, 1'b0}, 6);
    rst_n = 1'b0;
    #1;
    check("midreset_bitcount", 32'(bus.rx_bitcount), 32'd0);
    check("midreset_flags", 32'({bus.rx_avail, bus.rx_overrun, bus.rx_err_code}), 32'd0);
    check("midreset_data", 32'(bus.rx_data), 32'd0);
    last_data = 8'h00;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(5);
    send_frame(8'h3A, 1'b1, 1'b1, 1'b0);
    check("post_reset_data", 32'(bus.rx_data), 32'h3A);
    check("post_reset_avail", 32'(bus.rx_avail), 32'd1);

    // Host transmitting: falls counted, nothing captured or reported
    bus.tx_mode = 1'b1;
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    bus.tx_mode = 1'b0;
    check("tx_data_hold", 32'(bus.rx_data), 32'h3A);

    wait_cycles(10);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
